// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 8-digit display scanner.
// FSM encoding, segment codes and idle output levels.
package display_scan_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BLANK = 2'd1;
  localparam state_t ST_DRIVE = 2'd2;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [2:0] SEL_TOP = 3'd7;

  // active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/display_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-low
// seven-segment pattern.
module hex_to_seg
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  // one pattern per nibble value
  always_comb begin
    seg_n_o = SEG_OFF;
    unique case (hex_i)
      4'h0: seg_n_o = SEG_0;
      4'h1: seg_n_o = SEG_1;
      4'h2: seg_n_o = SEG_2;
      4'h3: seg_n_o = SEG_3;
      4'h4: seg_n_o = SEG_4;
      4'h5: seg_n_o = SEG_5;
      4'h6: seg_n_o = SEG_6;
      4'h7: seg_n_o = SEG_7;
      4'h8: seg_n_o = SEG_8;
      4'h9: seg_n_o = SEG_9;
      4'hA: seg_n_o = SEG_A;
      4'hB: seg_n_o = SEG_B;
      4'hC: seg_n_o = SEG_C;
      4'hD: seg_n_o = SEG_D;
      4'hE: seg_n_o = SEG_E;
      4'hF: seg_n_o = SEG_F;
      default: seg_n_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed display scanner with
// blanking gap, PWM brightness and leading-zero suppression.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] digit_mask,
  input  logic [7:0] dp,
  input  logic       lzb,
  input  logic [2:0] bright,
  input  logic [3:0] mux_o,
  output logic [2:0] sel,
  output logic [7:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'(BLANK_CYC - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          lz_seen_q, lz_seen_d;
  logic [3:0]    digit_q, digit_d;

  logic [7:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;
  logic          ft_q, ft_d;

  logic [6:0]    seg_dec;
  logic          drive;
  logic          lz_blank;
  logic          duty_on;
  logic          dwell_end;

  hex_to_seg u_hex (
    .hex_i   (digit_q),
    .seg_n_o (seg_dec)
  );

  assign dwell_end = (cnt_q == CNT_LAST);
  assign drive     = en && (state_q == ST_DRIVE);
  assign lz_blank  = lzb && !lz_seen_q &&
                     (digit_q == 4'd0) &&
                     (sel_q != 3'd0);
  assign duty_on   = (cnt_q[2:0] <= bright);

  // scan sequencer: dwell counter, digit select, capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    lz_seen_d = lz_seen_q;
    digit_d   = digit_q;
    if (!en) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      sel_d     = SEL_TOP;
      lz_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            digit_d = mux_o;
            if (digit_mask[sel_q] &&
                ((mux_o != 4'd0) ||
                 (sel_q == 3'd0)))
              lz_seen_d = 1'b1;
          end
        end
        ST_DRIVE: begin
          if (dwell_end) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (sel_q == 3'd0) begin
              sel_d     = SEL_TOP;
              lz_seen_d = 1'b0;
            end else begin
              sel_d = sel_q - 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          sel_d     = SEL_TOP;
          lz_seen_d = 1'b0;
        end
      endcase
    end
  end

  // output decision, registered one cycle behind the FSM
  always_comb begin
    an_n_d  = AN_OFF;
    seg_n_d = SEG_OFF;
    dp_n_d  = 1'b1;
    ft_d    = 1'b0;
    if (drive) begin
      seg_n_d = seg_dec;
      dp_n_d  = ~dp[sel_q];
      ft_d    = dwell_end && (sel_q == 3'd0);
      if (digit_mask[sel_q] && !lz_blank && duty_on)
        an_n_d[sel_q] = 1'b0;
    end
  end

  // sequencer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= SEL_TOP;
      lz_seen_q <= 1'b0;
      digit_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      lz_seen_q <= lz_seen_d;
      digit_q   <= digit_d;
    end
  end

  // glitch-free registered display drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n_q  <= AN_OFF;
      seg_n_q <= SEG_OFF;
      dp_n_q  <= 1'b1;
      ft_q    <= 1'b0;
    end else begin
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      ft_q    <= ft_d;
    end
  end

  assign sel        = sel_q;
  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a time-based
// reference model queues expected outputs, a monitor checks them.
module tb_display_scan_ctrl;

  localparam int SD = 16;
  localparam int BL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       lzb = 1'b0;
  logic [7:0] digit_mask = 8'h00;
  logic [7:0] dp = 8'h00;
  logic [2:0] bright = 3'd0;
  logic [3:0] mux_o;
  logic [2:0] sel;
  logic [7:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       frame_tick;

  logic [3:0] mux_dig [8];

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  int exp_ft = 0;
  int got_ft = 0;

  assign mux_o = mux_dig[sel];

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_mask (digit_mask),
    .dp         (dp),
    .lzb        (lzb),
    .bright     (bright),
    .mux_o      (mux_o),
    .sel        (sel),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] hi;
    case (v)
      4'h0: hi = 7'h3F;
      4'h1: hi = 7'h06;
      4'h2: hi = 7'h5B;
      4'h3: hi = 7'h4F;
      4'h4: hi = 7'h66;
      4'h5: hi = 7'h6D;
      4'h6: hi = 7'h7D;
      4'h7: hi = 7'h07;
      4'h8: hi = 7'h7F;
      4'h9: hi = 7'h6F;
      4'hA: hi = 7'h77;
      4'hB: hi = 7'h7C;
      4'hC: hi = 7'h39;
      4'hD: hi = 7'h5E;
      4'hE: hi = 7'h79;
      default: hi = 7'h71;
    endcase
    return ~hi;
  endfunction

  // a zero digit is suppressed if no visible nonzero digit precedes it
  function automatic bit blanked(input int s);
    if (!lzb || s == 0 || mux_dig[s] != 4'd0)
      return 1'b0;
    for (int j = s + 1; j < 8; j++)
      if (digit_mask[j] && mux_dig[j] != 4'd0)
        return 1'b0;
    return 1'b1;
  endfunction

  // expected outputs after this edge, from enabled-cycle count k
  task automatic model_push();
    exp_t e;
    int q, d, ph, s;
    e.sel = 3'd7;
    e.an  = 8'hFF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.ft  = 1'b0;
    if (!rst_n || !en) begin
      k = 0;
    end else begin
      k++;
      e.sel = 3'(7 - ((k - 1) / SD) % 8);
      q = k - 2;
      if (q >= 0) begin
        d  = q / SD;
        ph = q % SD;
        s  = 7 - d % 8;
        if (ph >= BL) begin
          e.seg = seg_of(mux_dig[s]);
          e.dp  = ~dp[s];
          if (digit_mask[s] && !blanked(s) &&
              (ph % 8) <= int'(bright))
            e.an[s] = 1'b0;
        end
        if (ph == SD - 1 && s == 0) begin
          e.ft = 1'b1;
          exp_ft++;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_push();
    #1;
  endtask

  task automatic jitter();
    bright = 3'($urandom);
    dp = 8'($urandom);
    if (!lzb)
      digit_mask = 8'($urandom);
  endtask

  task automatic run(input int n, input bit jit);
    repeat (n) begin
      tick();
      if (jit)
        jitter();
    end
  endtask

  // entered at posedge+1; pulses reset between edges
  task automatic async_reset(input int hold);
    #6;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sel, an_n, seg_n, dp_n, frame_tick} !==
        {3'd7, 8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got sel=%h an=%h seg=%h dp=%b ft=%b want 7/ff/7f/1/0",
               sel, an_n, seg_n, dp_n, frame_tick);
    end
    #1;
    repeat (hold) tick();
    #7;
    rst_n = 1'b1;
  endtask

  task automatic set_demo_digits();
    mux_dig[7] = 4'd0;
    mux_dig[6] = 4'd0;
    for (int i = 0; i < 6; i++)
      mux_dig[i] = 4'(6 - i);
  endtask

  initial begin : mon
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {sel, an_n, seg_n, dp_n, frame_tick};
        if (frame_tick === 1'b1)
          got_ft++;
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL scan t=%0t: got sel=%h an=%h seg=%h dp=%b ft=%b want sel=%h an=%h seg=%h dp=%b ft=%b",
                   $time, g.sel, g.an, g.seg, g.dp, g.ft,
                   e.sel, e.an, e.seg, e.dp, e.ft);
        end
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < 8; i++)
      mux_dig[i] = 4'd0;
    run(3, 1'b0);
    rst_n = 1'b1;
    run(2, 1'b0);

    set_demo_digits();
    digit_mask = 8'hFF;
    lzb = 1'b0;
    bright = 3'd7;
    dp = 8'h5A;
    en = 1'b1;
    run(260, 1'b0);
    en = 1'b0;
    run(3, 1'b0);

    lzb = 1'b1;
    en = 1'b1;
    run(260, 1'b0);
    en = 1'b0;
    run(3, 1'b0);

    for (int i = 0; i < 8; i++)
      mux_dig[i] = 4'd0;
    en = 1'b1;
    run(140, 1'b0);
    en = 1'b0;
    run(3, 1'b0);

    set_demo_digits();
    lzb = 1'b0;
    bright = 3'd1;
    en = 1'b1;
    run(140, 1'b0);
    en = 1'b0;
    run(3, 1'b0);

    bright = 3'd7;
    en = 1'b1;
    run(70, 1'b0);
    en = 1'b0;
    run(4, 1'b0);
    en = 1'b1;
    run(40, 1'b0);
    async_reset(2);
    run(150, 1'b0);

    en = 1'b0;
    run(2, 1'b0);
    digit_mask = 8'h00;
    en = 1'b1;
    run(140, 1'b0);

    for (int ep = 0; ep < 10; ep++) begin
      en = 1'b0;
      run(2, 1'b0);
      for (int i = 0; i < 8; i++)
        mux_dig[i] = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      digit_mask = 8'($urandom);
      dp = 8'($urandom);
      lzb = 1'($urandom_range(0, 1));
      bright = 3'($urandom);
      en = 1'b1;
      run(int'($urandom_range(40, 300)), 1'b1);
      if ($urandom_range(0, 2) == 0)
        async_reset(int'($urandom_range(1, 3)));
    end

    en = 1'b0;
    run(3, 1'b0);
    repeat (4) @(negedge clk);
    #1;

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    n_cmp++;
    if (got_ft != exp_ft) begin
      n_bad++;
      $display("FAIL frame_count: got %0d ticks want %0d", got_ft, exp_ft);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
